// File: rtl/eco32f_pkg.sv
// Shared constants and types for the eco32f fetch stage.
package eco32f_pkg;

  localparam logic [31:0] ECO32F_RESET_PC = 32'hE000_0000;
  localparam logic [31:0] ECO32F_NOP_INSN = 32'h0000_0000;

  localparam logic [1:0] ECO32F_FETCH_IDLE  = 2'd0;
  localparam logic [1:0] ECO32F_FETCH_FETCH = 2'd1;
  localparam logic [1:0] ECO32F_FETCH_DROP  = 2'd2;
  localparam logic [1:0] ECO32F_FETCH_HALT  = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } eco32f_slot_t;

  function automatic logic [31:0] eco32f_word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/eco32f_fetch_skid.sv
// One-entry holding buffer for a fetch response that arrives while decode is stalled.
module eco32f_fetch_skid
  import eco32f_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  eco32f_slot_t data_i,
  output eco32f_slot_t data_o,
  output logic         valid_o
);

  eco32f_slot_t data_q;
  logic         valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/eco32f_fetch.sv
// eco32f instruction fetch: owns the PC, drives the single-outstanding ibus
// and feeds decode, inserting bubbles when no instruction is available.
module eco32f_fetch
  import eco32f_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ECO32F_RESET_PC,
  parameter logic [31:0] NOP_INSN = ECO32F_NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_pc,
  output logic        ibus_req,
  output logic [31:0] ibus_adr,
  input  logic        ibus_ack,
  input  logic        ibus_err,
  input  logic [31:0] ibus_dat_i,
  output logic [31:0] id_pc,
  output logic [31:0] id_insn,
  output logic        id_valid,
  output logic        id_exc_ibus_fault
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_insn_q, id_insn_d;
  logic        id_valid_q, id_valid_d;
  logic        id_fault_q, id_fault_d;

  logic         skid_push, skid_pop, skid_clear, skid_valid;
  eco32f_slot_t skid_in, skid_out;

  logic        resp_ack, resp_err, resp_any;
  logic [31:0] pc_inc, tgt;

  // Responses only count while a request is actually outstanding.
  assign resp_err = req_q & ibus_err;
  assign resp_ack = req_q & ibus_ack & ~ibus_err;
  assign resp_any = resp_ack | resp_err;
  assign pc_inc   = pc_q + 32'd4;
  assign tgt      = eco32f_word_align(branch_pc);

  eco32f_fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (skid_clear),
    .data_i  (skid_in),
    .data_o  (skid_out),
    .valid_o (skid_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    adr_d      = adr_q;
    id_pc_d    = id_pc_q;
    id_insn_d  = id_insn_q;
    id_valid_d = id_valid_q;
    id_fault_d = id_fault_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
    skid_in    = '{pc: pc_q, insn: ibus_dat_i, fault: 1'b0};

    if (branch_valid) begin
      pc_d       = tgt;
      id_insn_d  = NOP_INSN;
      id_valid_d = 1'b0;
      id_fault_d = 1'b0;
      skid_clear = 1'b1;
      if (!req_q || resp_any) begin
        state_d = ECO32F_FETCH_FETCH;
        req_d   = 1'b1;
        adr_d   = tgt;
      end else begin
        state_d = ECO32F_FETCH_DROP;
      end
    end else begin
      // Default ID update; the FETCH accept path below overrides it.
      if (!if_stall) begin
        if (skid_valid) begin
          skid_pop   = 1'b1;
          id_pc_d    = skid_out.pc;
          id_insn_d  = skid_out.insn;
          id_valid_d = 1'b1;
          id_fault_d = skid_out.fault;
        end else begin
          id_insn_d  = NOP_INSN;
          id_valid_d = 1'b0;
          id_fault_d = 1'b0;
        end
      end

      case (state_q)
        ECO32F_FETCH_IDLE: begin
          state_d = ECO32F_FETCH_FETCH;
          req_d   = 1'b1;
          adr_d   = pc_q;
        end
        ECO32F_FETCH_FETCH: begin
          if (resp_err) begin
            state_d = ECO32F_FETCH_HALT;
            req_d   = 1'b0;
            if (if_stall) begin
              skid_push = 1'b1;
              skid_in   = '{pc: pc_q, insn: NOP_INSN, fault: 1'b1};
            end else begin
              id_pc_d    = pc_q;
              id_insn_d  = NOP_INSN;
              id_valid_d = 1'b1;
              id_fault_d = 1'b1;
            end
          end else if (resp_ack) begin
            pc_d = pc_inc;
            if (if_stall) begin
              skid_push = 1'b1;
              req_d     = 1'b0;
            end else begin
              id_pc_d    = pc_q;
              id_insn_d  = ibus_dat_i;
              id_valid_d = 1'b1;
              id_fault_d = 1'b0;
              adr_d      = pc_inc;
            end
          end else if (!req_q && skid_valid && !if_stall) begin
            req_d = 1'b1;
            adr_d = pc_q;
          end
        end
        ECO32F_FETCH_DROP: begin
          if (resp_any) begin
            state_d = ECO32F_FETCH_FETCH;
            req_d   = 1'b1;
            adr_d   = pc_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ECO32F_FETCH_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      adr_q      <= RESET_PC;
      id_pc_q    <= RESET_PC;
      id_insn_q  <= NOP_INSN;
      id_valid_q <= 1'b0;
      id_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      adr_q      <= adr_d;
      id_pc_q    <= id_pc_d;
      id_insn_q  <= id_insn_d;
      id_valid_q <= id_valid_d;
      id_fault_q <= id_fault_d;
    end
  end

  assign ibus_req          = req_q;
  assign ibus_adr          = adr_q;
  assign id_pc             = id_pc_q;
  assign id_insn           = id_insn_q;
  assign id_valid          = id_valid_q;
  assign id_exc_ibus_fault = id_fault_q;

endmodule

// File: tb/tb_eco32f_fetch.sv
// Self-checking bench for eco32f_fetch: vector table plus hand-written corner sequences.
module tb_eco32f_fetch;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        branch_valid;
  logic [31:0] branch_pc;
  logic        ibus_req;
  logic [31:0] ibus_adr;
  logic        ibus_ack;
  logic        ibus_err;
  logic [31:0] ibus_dat_i;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
  logic        id_valid;
  logic        id_exc_ibus_fault;

  eco32f_fetch #(
    .RESET_PC (32'hE000_0000),
    .NOP_INSN (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .if_stall          (if_stall),
    .branch_valid      (branch_valid),
    .branch_pc         (branch_pc),
    .ibus_req          (ibus_req),
    .ibus_adr          (ibus_adr),
    .ibus_ack          (ibus_ack),
    .ibus_err          (ibus_err),
    .ibus_dat_i        (ibus_dat_i),
    .id_pc             (id_pc),
    .id_insn           (id_insn),
    .id_valid          (id_valid),
    .id_exc_ibus_fault (id_exc_ibus_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        st;
    logic        ak;
    logic        er;
    logic [31:0] dat;
    logic        push;
    logic        e_req;
    logic [31:0] e_adr;
    logic        e_valid;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[12];
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] cur_adr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock; then pop the scoreboard if ID was free to take a new word.
  task automatic step();
    logic upd;
    exp_t e;
    upd = rst && !if_stall && !branch_valid;
    @(posedge clk);
    #1;
    if (upd && id_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got id_pc %h with nothing expected", id_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_id_pc", id_pc, e.pc);
        chk("sb_id_insn", id_insn, e.insn);
        chk("sb_id_fault", 32'(id_exc_ibus_fault), 32'(e.fault));
      end
    end
    if (!id_valid) begin
      chk("bubble_insn", id_insn, 32'h0);
      chk("bubble_fault", 32'(id_exc_ibus_fault), 32'h0);
    end
  endtask

  task automatic cyc(input string nm, input logic st, input logic ak, input logic er,
                     input logic [31:0] dat, input logic br, input logic [31:0] bpc,
                     input logic push, input logic e_req, input logic [31:0] e_adr,
                     input logic e_valid);
    exp_t e;
    if_stall     = st;
    ibus_ack     = ak;
    ibus_err     = er;
    ibus_dat_i   = dat;
    branch_valid = br;
    branch_pc    = bpc;
    if (push) begin
      e.pc    = cur_adr;
      e.insn  = er ? 32'h0 : dat;
      e.fault = er;
      sb.push_back(e);
    end
    step();
    chk({nm, "_req"}, 32'(ibus_req), 32'(e_req));
    chk({nm, "_adr"}, ibus_adr, e_adr);
    chk({nm, "_valid"}, 32'(id_valid), 32'(e_valid));
    cur_adr = e_adr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          st    ak    er    dat           push  req   adr            valid
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hE000_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0000, 1'b1, 1'b1, 32'hE000_0004, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'hE000_0004, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'hE000_0004, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'hE000_0004, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hE000_0008, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'hA200_0002, 1'b1, 1'b1, 32'hE000_000C, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'hA300_0003, 1'b1, 1'b1, 32'hE000_0010, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hE000_0010, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hE000_0010, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hE000_0010, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hE000_0010, 1'b0};

    rst          = 1'b0;
    if_stall     = 1'b0;
    branch_valid = 1'b0;
    branch_pc    = 32'h0;
    ibus_ack     = 1'b0;
    ibus_err     = 1'b0;
    ibus_dat_i   = 32'h0;
    step();
    step();
    chk("rst_req", 32'(ibus_req), 32'h0);
    chk("rst_adr", ibus_adr, 32'hE000_0000);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_insn", id_insn, 32'h0);
    chk("rst_id_pc", id_pc, 32'hE000_0000);
    chk("rst_fault", 32'(id_exc_ibus_fault), 32'h0);
    cur_adr = 32'hE000_0000;

    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].st, tbl[i].ak, tbl[i].er, tbl[i].dat, 1'b0, 32'h0,
          tbl[i].push, tbl[i].e_req, tbl[i].e_adr, tbl[i].e_valid);
    end

    // Redirect while E0000010 is outstanding: its late response must be dropped.
    cyc("br_drop",   1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_1003, 1'b0, 1'b1, 32'hE000_0010, 1'b0);
    cyc("drop_wait", 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'hE000_0010, 1'b0);
    cyc("drop_ack",  1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_1000, 1'b0);
    cyc("tgt_ack",   1'b0, 1'b1, 1'b0, 32'hB000_0000, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_1004, 1'b1);
    cyc("br_ack",    1'b0, 1'b1, 1'b0, 32'hBAD0_BAD0, 1'b1, 32'hE000_0020, 1'b0, 1'b1, 32'hE000_0020, 1'b0);

    // Bus fault, halt, then restart by redirect.
    cyc("fault",     1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'hE000_0020, 1'b1);
    chk("fault_flag", 32'(id_exc_ibus_fault), 32'h1);
    cyc("halt",      1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'hE000_0020, 1'b0);
    cyc("halt_ack",  1'b0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 1'b0, 32'hE000_0020, 1'b0);
    cyc("halt_br",   1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hE000_0008, 1'b0, 1'b1, 32'hE000_0008, 1'b0);
    cyc("c0",        1'b0, 1'b1, 1'b0, 32'hC0C0_C0C0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hE000_000C, 1'b1);

    // PC wrap-around, then a fault that arrives while decode is stalled.
    cyc("br_wrap",   1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc("wrap_ack",  1'b0, 1'b1, 1'b0, 32'hD0D0_D0D0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b1);
    cyc("flt_stall", 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b1);
    chk("flt_stall_held", id_insn, 32'hD0D0_D0D0);
    cyc("flt_rel",   1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b1);

    // Repeated redirect while in DROP only retargets.
    cyc("br2",       1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000, 1'b0);
    cyc("br_pend",   1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b0, 1'b1, 32'h0000_2000, 1'b0);
    cyc("br_pend2",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_400B, 1'b0, 1'b1, 32'h0000_2000, 1'b0);
    cyc("drop_ack2", 1'b0, 1'b1, 1'b0, 32'hEEEE_EEEE, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_4008, 1'b0);

    // Reset in the middle of a request; the late ack must be ignored.
    rst = 1'b0;
    cyc("rst_mid",   1'b0, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 32'h0,         1'b0, 1'b0, 32'hE000_0000, 1'b0);
    chk("rst_mid_id_pc", id_pc, 32'hE000_0000);
    rst = 1'b1;
    cyc("late_ack",  1'b0, 1'b1, 1'b0, 32'h6666_6666, 1'b0, 32'h0,         1'b0, 1'b1, 32'hE000_0000, 1'b0);
    cyc("restart",   1'b0, 1'b1, 1'b0, 32'hF0F0_F0F0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hE000_0004, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
